// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light sequencer and its delay counter.
// Holds the state encoding and the phase-length helpers both sides must agree on.
package tl_pkg;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } tl_state_e;

  // Red lasts half the counter range: the counter is loaded at mid-scale and
  // the sequencer leaves red when it wraps.
  function automatic int red_delay(input int num_of_bit);
    return (2 ** num_of_bit) / 2;
  endfunction

  function automatic int yellow_delay(input int num_of_bit, input int ratio);
    return red_delay(num_of_bit) / (ratio + 1);
  endfunction

  function automatic int green_delay(input int num_of_bit, input int ratio);
    return yellow_delay(num_of_bit, ratio) * ratio;
  endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Lamp and counter-load decode for the traffic-light sequencer.
// Pure combinational decode of the registered state (and pedestrian flag when
// TL_PED_EN is defined); keeps the lamps one-hot by construction.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  tl_state_e state,
`ifdef TL_PED_EN
  input  logic      ped_flag,
  output logic      ped_walk,
`endif
  output logic      red,
  output logic      yellow,
  output logic      green,
  output logic      cnt_set
);

  // One lamp per state; S_LOAD shows red while asking the counter to reload.
  always_comb begin
    red     = 1'b0;
    yellow  = 1'b0;
    green   = 1'b0;
    cnt_set = 1'b0;
    case (state)
      S_LOAD: begin
        red     = 1'b1;
        cnt_set = 1'b1;
      end
      S_RED:    red    = 1'b1;
      S_GREEN:  green  = 1'b1;
      S_YELLOW: yellow = 1'b1;
      default:  red    = 1'b1;
    endcase
  end

`ifdef TL_PED_EN
  // Walk is only shown during the counted red phase, never in S_LOAD.
  always_comb begin
    ped_walk = ped_flag && (state == S_RED);
  end
`endif

endmodule

// File: rtl/traffic_light_sequencer.sv
// Traffic-light sequencer: master for the external delay counter.
// Loads the counter, steps RED -> GREEN -> YELLOW -> RED from the returned
// count, and flags loss of sync when the count does not fit the phase.
// Optional pedestrian walk request is built when TL_PED_EN is defined.
// state_dbg exposes the registered FSM state for observation.
module traffic_light_sequencer
  import tl_pkg::*;
#(
  parameter int NUM_OF_BIT         = 4,
  parameter int GREEN_YELLOW_RATIO = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [NUM_OF_BIT-1:0] cnt_in,
  output logic                  cnt_set,
  output logic                  cnt_clr,
  output logic                  red,
  output logic                  yellow,
  output logic                  green,
  output logic                  phase_start,
  output logic                  sync_err,
`ifdef TL_PED_EN
  input  logic                  ped_req,
  output logic                  ped_walk,
`endif
  output tl_state_e             state_dbg
);

  localparam int RED_DELAY    = red_delay(NUM_OF_BIT);
  localparam int YELLOW_DELAY = yellow_delay(NUM_OF_BIT, GREEN_YELLOW_RATIO);
  localparam int GREEN_DELAY  = green_delay(NUM_OF_BIT, GREEN_YELLOW_RATIO);

  // Count thresholds, all at counter width.
  localparam logic [NUM_OF_BIT-1:0] RED_MIN    = NUM_OF_BIT'(RED_DELAY);
  localparam logic [NUM_OF_BIT-1:0] RED_END    = '1;
  localparam logic [NUM_OF_BIT-1:0] GREEN_END  = NUM_OF_BIT'(GREEN_DELAY - 1);
  localparam logic [NUM_OF_BIT-1:0] YELLOW_END = NUM_OF_BIT'(GREEN_DELAY + YELLOW_DELAY - 1);

  tl_state_e state;
  tl_state_e state_next;
  logic      out_of_range;
  logic      phase_start_q;

  // Next state and sync check. Red runs on the upper half of the count,
  // green/yellow on the lower half after the wrap; anything else is lost sync.
  always_comb begin
    state_next   = state;
    out_of_range = 1'b0;
    case (state)
      S_LOAD: state_next = S_RED;
      S_RED: begin
        if (cnt_in < RED_MIN) begin
          out_of_range = 1'b1;
          state_next   = S_LOAD;
        end else if (cnt_in == RED_END) begin
          state_next = S_GREEN;
        end
      end
      S_GREEN: begin
        if (cnt_in >= RED_MIN) begin
          out_of_range = 1'b1;
          state_next   = S_LOAD;
        end else if (cnt_in == GREEN_END) begin
          state_next = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (cnt_in >= RED_MIN) begin
          out_of_range = 1'b1;
          state_next   = S_LOAD;
        end else if (cnt_in == YELLOW_END) begin
          state_next = S_LOAD;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  // State register; phase_start is registered so it aligns with the first
  // cycle of the new GREEN, YELLOW or S_LOAD phase. Reset entry does not pulse.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state         <= S_LOAD;
      phase_start_q <= 1'b0;
    end else begin
      state         <= state_next;
      phase_start_q <= (state_next != state) && (state_next != S_RED);
    end
  end

`ifdef TL_PED_EN
  logic ped_flag;

  // Sticky pedestrian request; a new press wins over the clear so a press in
  // the last red cycle carries into the next red phase.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      ped_flag <= 1'b0;
    end else if (ped_req) begin
      ped_flag <= 1'b1;
    end else if ((state == S_RED) && (state_next == S_GREEN)) begin
      ped_flag <= 1'b0;
    end
  end
`endif

  tl_lamp_decode u_decode (
    .state    (state),
`ifdef TL_PED_EN
    .ped_flag (ped_flag),
    .ped_walk (ped_walk),
`endif
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .cnt_set  (cnt_set)
  );

  // Sync error is reported in the cycle the bad count is seen; reset masks it.
  always_comb begin
    sync_err = Reset && out_of_range;
  end

  assign phase_start = phase_start_q;
  assign cnt_clr     = 1'b0;
  assign state_dbg   = state;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer paired with a delay counter model.
// Reference model tracks the position inside the 15-cycle light period.
module tb_traffic_light_sequencer;
  import tl_pkg::*;

  localparam int NB           = 4;
  localparam int RATIO        = 2;
  localparam int RED_DELAY    = (2 ** NB) / 2;
  localparam int YELLOW_DELAY = RED_DELAY / (RATIO + 1);
  localparam int GREEN_DELAY  = YELLOW_DELAY * RATIO;
  localparam int RED_LEN      = RED_DELAY + 1;
  localparam int YEL_START    = RED_LEN + GREEN_DELAY;
  localparam int PERIOD       = RED_LEN + GREEN_DELAY + YELLOW_DELAY;

  // ---------------- clock / reset / signals ----------------
  logic          CLK       = 1'b0;
  logic          Reset     = 1'b0;
  logic [NB-1:0] cnt_q     = '0;
  logic [NB-1:0] force_val = '0;
  logic          force_en  = 1'b0;
  logic [NB-1:0] cnt_in;
  logic          cnt_set, cnt_clr, red, yellow, green, phase_start, sync_err;
  tl_state_e     state_dbg;
`ifdef TL_PED_EN
  logic          ped_req = 1'b0;
  logic          ped_walk;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  // Delay counter: clear, load mid-scale, otherwise count up and wrap.
  always @(posedge CLK) begin
    if (cnt_clr)      cnt_q <= '0;
    else if (cnt_set) cnt_q <= NB'(RED_DELAY);
    else              cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_in = force_en ? force_val : cnt_q;

  traffic_light_sequencer #(.NUM_OF_BIT(NB), .GREEN_YELLOW_RATIO(RATIO)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .cnt_in      (cnt_in),
    .cnt_set     (cnt_set),
    .cnt_clr     (cnt_clr),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .phase_start (phase_start),
    .sync_err    (sync_err),
`ifdef TL_PED_EN
    .ped_req     (ped_req),
    .ped_walk    (ped_walk),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos 0 = load cycle, 1..8 counted red, 9..12 green, 13..14 yellow.
  int   m_pos   = 0;
  logic m_ps    = 1'b0;
  logic m_valid = 1'b0;
  logic m_flag  = 1'b0;

  function automatic bit m_err(input int pos, input logic [NB-1:0] c);
    if (pos >= 1 && pos <= RED_DELAY) return (int'(c) < RED_DELAY);
    if (pos > RED_DELAY)              return (int'(c) >= RED_DELAY);
    return 1'b0;
  endfunction

  function automatic int m_next(input int pos, input logic [NB-1:0] c);
    if (m_err(pos, c)) return 0;
    return (pos + 1) % PERIOD;
  endfunction

  function automatic bit m_entry(input int pos);
    return (pos == 0) || (pos == RED_LEN) || (pos == YEL_START);
  endfunction

  function automatic tl_state_e m_state(input int pos);
    if (pos == 0)         return S_LOAD;
    if (pos < RED_LEN)    return S_RED;
    if (pos < YEL_START)  return S_GREEN;
    return S_YELLOW;
  endfunction

  always @(posedge CLK) begin
    if (!Reset) begin
      m_pos   <= 0;
      m_ps    <= 1'b0;
      m_valid <= 1'b1;
      m_flag  <= 1'b0;
    end else begin
      m_pos <= m_next(m_pos, cnt_in);
      m_ps  <= m_entry(m_next(m_pos, cnt_in));
`ifdef TL_PED_EN
      if (ped_req) m_flag <= 1'b1;
      else if (m_pos == RED_DELAY && m_next(m_pos, cnt_in) == RED_LEN) m_flag <= 1'b0;
`endif
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("red",         red,         m_pos < RED_LEN);
      check("green",       green,       (m_pos >= RED_LEN) && (m_pos < YEL_START));
      check("yellow",      yellow,      m_pos >= YEL_START);
      check("one_hot",     $countones({red, yellow, green}), 1);
      check("cnt_set",     cnt_set,     m_pos == 0);
      check("cnt_clr",     cnt_clr,     0);
      check("phase_start", phase_start, m_ps);
      check("sync_err",    sync_err,    Reset && m_err(m_pos, cnt_in));
      check("state_dbg",   state_dbg,   m_state(m_pos));
`ifdef TL_PED_EN
      check("ped_walk",    ped_walk,    m_flag && (m_pos >= 1) && (m_pos < RED_LEN));
`endif
    end
  end

  // ---------------- driver helpers ----------------
  // which: 0 load cycle, 1 counted red, 2 green; cval >= 0 also requires cnt_in.
  task automatic wait_cond(input int which, input int cval);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(posedge CLK);
      #2;
      case (which)
        0:       hit = (cnt_set === 1'b1);
        1:       hit = (red === 1'b1) && (cnt_set === 1'b0);
        default: hit = (green === 1'b1);
      endcase
      if (cval >= 0 && int'(cnt_in) != cval) hit = 1'b0;
    end
    n_vec++;
    if (!hit) begin
      n_bad++;
      $display("FAIL wait_cond(%0d,%0d): condition not reached, got 0 expected 1", which, cval);
    end
  endtask

  int seq[45];
  int n_red, n_green, n_yel, n_ps, n_walk;

  // ---------------- directed tests ----------------
  initial begin
    // Test 1: reset then first load.
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("t1_rst_red",     red,         1);
    check("t1_rst_set",     cnt_set,     1);
    check("t1_rst_green",   green,       0);
    check("t1_rst_ps",      phase_start, 0);
    check("t1_rst_syncerr", sync_err,    0);
    @(posedge CLK);
    #2 Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t1_red",     red,     1);
    check("t1_set_off", cnt_set, 0);
    check("t1_cnt8",    cnt_in,  8);

    // Test 2: 45 cycles of free run starting at a natural load cycle.
    wait_cond(2, -1);
    wait_cond(0, -1);
    n_red = 0; n_green = 0; n_yel = 0; n_ps = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge CLK);
      seq[i] = red ? 0 : (green ? 1 : (yellow ? 2 : 3));
      if (red)         n_red++;
      if (green)       n_green++;
      if (yellow)      n_yel++;
      if (phase_start) n_ps++;
    end
    check("t2_red_cycles",    n_red,   27);
    check("t2_green_cycles",  n_green, 12);
    check("t2_yellow_cycles", n_yel,   6);
    check("t2_phase_starts",  n_ps,    9);
    check("t2_seq8",  seq[8],  0);
    check("t2_seq9",  seq[9],  1);
    check("t2_seq12", seq[12], 1);
    check("t2_seq13", seq[13], 2);
    check("t2_seq14", seq[14], 2);
    check("t2_seq15", seq[15], 0);
    check("t2_seq44", seq[44], 2);

    // Test 3: forced out-of-range count during red.
    wait_cond(1, -1);
    force_val = 4'd3;
    force_en  = 1'b1;
    @(negedge CLK);
    check("t3_syncerr", sync_err, 1);
    check("t3_red",     red,      1);
    @(posedge CLK);
    #2 force_en = 1'b0;
    @(negedge CLK);
    check("t3_load_red",  red,         1);
    check("t3_load_set",  cnt_set,     1);
    check("t3_err_clear", sync_err,    0);
    check("t3_load_ps",   phase_start, 1);

    // Test 4: reset in the middle of green.
    wait_cond(2, 2);
    Reset = 1'b0;
    @(posedge CLK);
    #2 Reset = 1'b1;
    @(negedge CLK);
    check("t4_red",     red,         1);
    check("t4_green",   green,       0);
    check("t4_set",     cnt_set,     1);
    check("t4_syncerr", sync_err,    0);
    check("t4_ps",      phase_start, 0);
    repeat (20) @(posedge CLK);

`ifdef TL_PED_EN
    // Test 5: pedestrian press during green.
    wait_cond(2, -1);
    ped_req = 1'b1;
    @(posedge CLK);
    #2 ped_req = 1'b0;
    n_walk = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (ped_walk) n_walk++;
    end
    check("t5_walk_cycles", n_walk, 8);
`endif

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
